wb_queue: RTL and testbench
===========================

# wb_queue

Parametrised writeback buffer placed between the memory stage and the register-file write port. It selects the writeback result (ALU, data memory or PC) at enqueue time and holds up to DEPTH completed instructions in program order. It drains them to the register file through a valid/ready handshake and commits per-flag updates to an architectural flags register as each entry retires. An optional forwarding port exposes the youngest pending result for any register address.

## Interface
Parameters:
- DW, 32, datapath width
- AW, 4, register-file address width
- DEPTH, 4, queue entries; power of two, ≥2
- NFLAG, 4, number of flags; bit 3 = O, 2 = S, 1 = C, 0 = Z

Ports:
- CLK  in  1  clock, rising edge
- RST_N  in  1  synchronous reset, active-low
- flush  in  1  discard all queued entries
- in_valid  in  1  memory stage offers an instruction
- in_ready  out  1  queue accepts this cycle
- in_PC  in  DW  PC-link value
- in_DM  in  DW  data-memory read value
- in_ALU  in  DW  ALU result
- S_MXRB  in  2  result select: 00 ALU, 01 DM, 10 PC, 11 zero
- in_rd  in  AW  destination register
- in_we  in  1  instruction writes a register
- in_flags  in  NFLAG  new flag values
- in_flag_we  in  NFLAG  per-flag write mask
- rf_valid  out  1  head entry requests a register write
- rf_ready  in  1  register file accepts the write
- rf_addr  out  AW  head destination
- rf_data  out  DW  head result
- out_flags  out  NFLAG  architectural flags
- fwd_addr  in  AW  forwarding lookup address
- fwd_hit  out  1  a pending entry writes fwd_addr
- fwd_data  out  DW  value of the youngest matching entry
- count  out  $clog2(DEPTH)+1  occupancy
- full, empty  out  1  occupancy status

## Operation
- Circular buffer with head and tail pointers. The wrap is implicit (power-of-two DEPTH). An extra count register disambiguates full from empty.
- Push = in_valid & in_ready & !flush. The mux is resolved at push: only the selected DW result is stored, together with rd, we, flags and flag_we.
- in_ready = !full & !flush. When full there is no same-cycle pass-through, even if a pop occurs in that cycle.
- Every instruction is enqueued, including those with we=0 and flag_we=0, so flag order is preserved.
- Head retires (pop) when !empty & !flush & (!head.we | rf_ready). An entry with we=0 retires without a handshake.
- rf_valid = !empty & head.we & !flush. rf_addr and rf_data are driven from the head and hold stable while rf_valid=1 and rf_ready=0.
- On pop: out_flags ← (out_flags & ~head.flag_we) | (head.flags & head.flag_we).
- Simultaneous push and pop: count is unchanged and both pointers advance.
- flush: head, tail and count are cleared on the next edge. out_flags are not modified. Neither a push nor a pop occurs in a flush cycle.
- Forwarding: combinational search of valid entries with we=1 and rd == fwd_addr. The youngest (closest to tail) wins. fwd_data is 0 when fwd_hit=0. A same-cycle incoming instruction is not searched.

## Timing
- Reset (RST_N=0 at an edge): count=0, empty=1, full=0, in_ready=1 after release, rf_valid=0, rf_addr=0, rf_data=0, out_flags=0, fwd_hit=0, fwd_data=0.
- Enqueue → rf_valid: 1 cycle minimum. An entry pushed at edge N can retire at edge N+1.
- Retire → out_flags visible: the edge of the pop. The new value appears in the following cycle.
- Reset asserted mid-drain: all entries are discarded without writes, and flags clear to 0.
- Throughput: 1 entry/cycle when rf_ready is held high.

## Configuration
- WB_FWD_EN defined: the forwarding search is implemented as described.
- WB_FWD_EN undefined: the search logic is not built. fwd_hit and fwd_data are tied to 0, and fwd_addr is unused. All other behaviour is identical.

## Test plan
- Reset, then push ALU=0x11, DM=0x22, PC=0x33 with S_MXRB=00/01/10, rd=1/2/3, rf_ready=1 → rf writes (1,0x11),(2,0x22),(3,0x33) on consecutive cycles. Also push S_MXRB=11 with rd=4 → write (4,0).
- rf_ready=0 and push 4 entries (DEPTH=4) → full=1, in_ready=0, count=4. Head stays stable. Set rf_ready=1 → 4 writes in order, then empty=1.
- Flags=0. Push flag_we=1000 flags=1111, then flag_we=0001 flags=0000, both with we=0 → out_flags=1000 after the first retire and 1000 after the second. No rf_valid is asserted.
- WB_FWD_EN defined, rf_ready=0. Push rd=5 data 0xA, then rd=5 data 0xB. fwd_addr=5 → fwd_hit=1, fwd_data=0xB. fwd_addr=6 → hit=0, data=0.
- 3 entries queued, assert flush for 1 cycle with in_valid=1 → count=0 next cycle, no rf writes occur, and out_flags are unchanged.
- Push at full while popping in the same cycle → the push is rejected (in_ready=0) and count drops by 1.

Source files
------------

// File: rtl/wb_queue_if.sv
// wb_queue_if: bundles the memory-stage, register-file, flag and forwarding signals of wb_queue.
// master = surrounding pipeline / bench side, slave = the queue itself.
interface wb_queue_if #(
   parameter int DW    = 32,
   parameter int AW    = 4,
   parameter int DEPTH = 4,
   parameter int NFLAG = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [DW-1:0]    in_PC;
   logic [DW-1:0]    in_DM;
   logic [DW-1:0]    in_ALU;
   logic [1:0]       S_MXRB;
   logic [AW-1:0]    in_rd;
   logic             in_we;
   logic [NFLAG-1:0] in_flags;
   logic [NFLAG-1:0] in_flag_we;
   logic             rf_valid;
   logic             rf_ready;
   logic [AW-1:0]    rf_addr;
   logic [DW-1:0]    rf_data;
   logic [NFLAG-1:0] out_flags;
   logic [AW-1:0]    fwd_addr;
   logic             fwd_hit;
   logic [DW-1:0]    fwd_data;
   logic [CW-1:0]    count;
   logic             full;
   logic             empty;

   modport master (
      output flush, in_valid, in_PC, in_DM, in_ALU, S_MXRB, in_rd, in_we,
             in_flags, in_flag_we, rf_ready, fwd_addr,
      input  in_ready, rf_valid, rf_addr, rf_data, out_flags, fwd_hit,
             fwd_data, count, full, empty
   );

   modport slave (
      input  flush, in_valid, in_PC, in_DM, in_ALU, S_MXRB, in_rd, in_we,
             in_flags, in_flag_we, rf_ready, fwd_addr,
      output in_ready, rf_valid, rf_addr, rf_data, out_flags, fwd_hit,
             fwd_data, count, full, empty
   );
endinterface

// File: rtl/wb_queue.sv
// wb_queue: in-order writeback buffer that drains to the register file and commits flags on retire.
// Define WB_FWD_EN to build the youngest-match forwarding search; otherwise fwd_hit/fwd_data are 0.
module wb_queue #(
   parameter int DW    = 32,
   parameter int AW    = 4,
   parameter int DEPTH = 4,
   parameter int NFLAG = 4
) (
   input logic        CLK,
   input logic        RST_N,
   wb_queue_if.slave  bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [DW-1:0]    data_q   [DEPTH];
   logic [AW-1:0]    rd_q     [DEPTH];
   logic [DEPTH-1:0] we_q;
   logic [NFLAG-1:0] flags_q  [DEPTH];
   logic [NFLAG-1:0] flagWe_q [DEPTH];

   logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]    count_q, count_d;
   logic [NFLAG-1:0] outFlags_q, outFlags_d;

   logic             full, empty, push, pop, headWe;
   logic [DW-1:0]    selData;

   assign full   = (count_q == CW'(DEPTH));
   assign empty  = (count_q == '0);
   assign headWe = we_q[head_q];

   assign push = bus.in_valid & bus.in_ready;
   assign pop  = !empty & !bus.flush & (!headWe | bus.rf_ready);

   assign bus.in_ready  = !full & !bus.flush;
   assign bus.rf_valid  = !empty & headWe & !bus.flush;
   assign bus.rf_addr   = empty ? '0 : rd_q[head_q];
   assign bus.rf_data   = empty ? '0 : data_q[head_q];
   assign bus.out_flags = outFlags_q;
   assign bus.count     = count_q;
   assign bus.full      = full;
   assign bus.empty     = empty;

   always_comb begin
      selData = '0;
      case (bus.S_MXRB)
         2'b00:   selData = bus.in_ALU;
         2'b01:   selData = bus.in_DM;
         2'b10:   selData = bus.in_PC;
         default: selData = '0;
      endcase
   end

   // Pointer wrap relies on DEPTH being a power of two; flush overrides push and pop.
   always_comb begin
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;
      outFlags_d = outFlags_q;
      if (bus.flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (pop) begin
            head_d     = head_q + 1'b1;
            outFlags_d = (outFlags_q & ~flagWe_q[head_q]) | (flags_q[head_q] & flagWe_q[head_q]);
         end
         if (push) begin
            tail_d = tail_q + 1'b1;
         end
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         outFlags_q <= '0;
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         outFlags_q <= outFlags_d;
      end
   end

   // Entry payload needs no reset: occupancy alone decides which slots are live.
   always_ff @(posedge CLK) begin
      if (push) begin
         data_q[tail_q]   <= selData;
         rd_q[tail_q]     <= bus.in_rd;
         we_q[tail_q]     <= bus.in_we;
         flags_q[tail_q]  <= bus.in_flags;
         flagWe_q[tail_q] <= bus.in_flag_we;
      end
   end

`ifdef WB_FWD_EN
   // Walk oldest to youngest so a later match overwrites an earlier one.
   always_comb begin
      logic [PW-1:0] idx;
      idx          = '0;
      bus.fwd_hit  = 1'b0;
      bus.fwd_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head_q + PW'(i);
         if ((CW'(i) < count_q) && we_q[idx] && (rd_q[idx] == bus.fwd_addr)) begin
            bus.fwd_hit  = 1'b1;
            bus.fwd_data = data_q[idx];
         end
      end
   end
`else
   assign bus.fwd_hit  = 1'b0;
   assign bus.fwd_data = '0;
`endif
endmodule

// File: tb/tb_wb_queue.sv
// tb_wb_queue: directed and random stimulus for wb_queue checked against a queue-based reference model.
module tb_wb_queue;
   localparam int DW    = 32;
   localparam int AW    = 4;
   localparam int DEPTH = 4;
   localparam int NFLAG = 4;

   typedef struct {
      logic             rstN;
      logic             flush;
      logic             valid;
      logic [DW-1:0]    pc;
      logic [DW-1:0]    dm;
      logic [DW-1:0]    alu;
      logic [1:0]       sel;
      logic [AW-1:0]    rd;
      logic             we;
      logic [NFLAG-1:0] flags;
      logic [NFLAG-1:0] fwe;
      logic             rfReady;
      logic [AW-1:0]    fwdAddr;
   } stim_t;

   typedef struct {
      logic [AW-1:0]    rd;
      logic             we;
      logic [DW-1:0]    data;
      logic [NFLAG-1:0] flags;
      logic [NFLAG-1:0] fwe;
   } entry_t;

   logic CLK = 1'b0;
   logic RST_N;
   always #5 CLK = ~CLK;

   wb_queue_if #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .NFLAG(NFLAG)) bus ();

   wb_queue #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .NFLAG(NFLAG)) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .bus   (bus)
   );

   entry_t           modelQ[$];
   logic [NFLAG-1:0] modelFlags = '0;
   int               compareCount = 0;
   int               failCount = 0;

   task automatic checkOutput(input string tag, input logic [DW-1:0] observed, input logic [DW-1:0] expected);
      compareCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   function automatic logic [DW-1:0] selectResult(input stim_t s);
      case (s.sel)
         2'd0:    return s.alu;
         2'd1:    return s.dm;
         2'd2:    return s.pc;
         default: return '0;
      endcase
   endfunction

   function automatic stim_t idleStim();
      stim_t s;
      s.rstN = 1'b1;  s.flush = 1'b0; s.valid = 1'b0;
      s.pc = '0;      s.dm = '0;      s.alu = '0;     s.sel = 2'd0;
      s.rd = '0;      s.we = 1'b0;    s.flags = '0;   s.fwe = '0;
      s.rfReady = 1'b1; s.fwdAddr = '0;
      return s;
   endfunction

   // One clock: drive, compare outputs against the model, clock, then advance the model.
   task automatic applyStimulus(input stim_t s);
      logic          expFull, expEmpty, expReady, expValid, expHit, doPush, doPop;
      logic [DW-1:0] expFwd;
      entry_t        e;
      @(negedge CLK);
      RST_N          = s.rstN;
      bus.flush      = s.flush;
      bus.in_valid   = s.valid;
      bus.in_PC      = s.pc;
      bus.in_DM      = s.dm;
      bus.in_ALU     = s.alu;
      bus.S_MXRB     = s.sel;
      bus.in_rd      = s.rd;
      bus.in_we      = s.we;
      bus.in_flags   = s.flags;
      bus.in_flag_we = s.fwe;
      bus.rf_ready   = s.rfReady;
      bus.fwd_addr   = s.fwdAddr;
      #1;
      expFull  = (modelQ.size() == DEPTH);
      expEmpty = (modelQ.size() == 0);
      expReady = !expFull && !s.flush;
      expValid = !expEmpty && modelQ[0].we && !s.flush;
      expHit   = 1'b0;
      expFwd   = '0;
`ifdef WB_FWD_EN
      foreach (modelQ[i]) begin
         if (modelQ[i].we && modelQ[i].rd == s.fwdAddr) begin
            expHit = 1'b1;
            expFwd = modelQ[i].data;
         end
      end
`endif
      checkOutput("in_ready",  DW'(bus.in_ready),  DW'(expReady));
      checkOutput("full",      DW'(bus.full),      DW'(expFull));
      checkOutput("empty",     DW'(bus.empty),     DW'(expEmpty));
      checkOutput("count",     DW'(bus.count),     DW'(modelQ.size()));
      checkOutput("out_flags", DW'(bus.out_flags), DW'(modelFlags));
      checkOutput("rf_valid",  DW'(bus.rf_valid),  DW'(expValid));
      if (expValid) begin
         checkOutput("rf_addr", DW'(bus.rf_addr), DW'(modelQ[0].rd));
         checkOutput("rf_data", bus.rf_data, modelQ[0].data);
      end
      checkOutput("fwd_hit",  DW'(bus.fwd_hit), DW'(expHit));
      checkOutput("fwd_data", bus.fwd_data, expFwd);

      doPush = s.valid && expReady;
      doPop  = !expEmpty && !s.flush && (!modelQ[0].we || s.rfReady);
      @(posedge CLK);
      if (!s.rstN) begin
         modelQ.delete();
         modelFlags = '0;
      end else if (s.flush) begin
         modelQ.delete();
      end else begin
         if (doPop) begin
            modelFlags = (modelFlags & ~modelQ[0].fwe) | (modelQ[0].flags & modelQ[0].fwe);
            void'(modelQ.pop_front());
         end
         if (doPush) begin
            e.rd = s.rd; e.we = s.we; e.data = selectResult(s);
            e.flags = s.flags; e.fwe = s.fwe;
            modelQ.push_back(e);
         end
      end
   endtask

   initial begin
      stim_t s;
      s = idleStim();
      s.rstN = 1'b0;
      applyStimulus(s);
      applyStimulus(s);
      applyStimulus(idleStim());
      @(negedge CLK);
      #1;
      checkOutput("rst_rf_addr", DW'(bus.rf_addr), '0);
      checkOutput("rst_rf_data", bus.rf_data, '0);

      $display("[TB] result select and back-to-back writes");
      for (int i = 0; i < 4; i++) begin
         s = idleStim();
         s.valid = 1'b1; s.we = 1'b1; s.rd = AW'(i + 1); s.sel = 2'(i);
         s.alu = 32'h11; s.dm = 32'h22; s.pc = 32'h33;
         applyStimulus(s);
      end
      for (int i = 0; i < 3; i++) applyStimulus(idleStim());

      $display("[TB] fill to full, then push at full while popping");
      for (int i = 0; i < 5; i++) begin
         s = idleStim();
         s.valid = 1'b1; s.we = 1'b1; s.rfReady = 1'b0; s.rd = AW'(8 + i); s.alu = 32'h100 + i;
         applyStimulus(s);
      end
      checkOutput("full_count", DW'(bus.count), DW'(DEPTH));
      s = idleStim();
      s.valid = 1'b1; s.we = 1'b1; s.rd = 4'hF; s.alu = 32'hDEAD;
      applyStimulus(s);
      for (int i = 0; i < 5; i++) applyStimulus(idleStim());

      $display("[TB] flag-only entries");
      s = idleStim();
      s.valid = 1'b1; s.flags = 4'b1111; s.fwe = 4'b1000;
      applyStimulus(s);
      s.flags = 4'b0000; s.fwe = 4'b0001;
      applyStimulus(s);
      applyStimulus(idleStim());
      applyStimulus(idleStim());
      checkOutput("flags_seq", DW'(bus.out_flags), DW'(4'b1000));

      $display("[TB] forwarding and flush");
      s = idleStim();
      s.valid = 1'b1; s.we = 1'b1; s.rfReady = 1'b0; s.rd = 4'd5; s.alu = 32'hA;
      applyStimulus(s);
      s.alu = 32'hB;
      applyStimulus(s);
      s.rd = 4'd7; s.alu = 32'hC;
      applyStimulus(s);
      s = idleStim(); s.rfReady = 1'b0; s.fwdAddr = 4'd5;
      applyStimulus(s);
      s.fwdAddr = 4'd6;
      applyStimulus(s);
      s = idleStim(); s.flush = 1'b1; s.valid = 1'b1; s.we = 1'b1; s.rd = 4'd9;
      applyStimulus(s);
      applyStimulus(idleStim());

      $display("[TB] reset during drain");
      for (int i = 0; i < 3; i++) begin
         s = idleStim();
         s.valid = 1'b1; s.we = 1'b1; s.rfReady = 1'b0; s.rd = AW'(i); s.alu = 32'h50 + i;
         s.flags = 4'b0110; s.fwe = 4'b0110;
         applyStimulus(s);
      end
      s = idleStim(); s.rstN = 1'b0;
      applyStimulus(s);
      applyStimulus(idleStim());

      $display("[TB] random traffic");
      for (int n = 0; n < 3000; n++) begin
         s.rstN    = ($urandom_range(0, 299) != 0);
         s.flush   = ($urandom_range(0, 15) == 0);
         s.valid   = ($urandom_range(0, 3) != 0);
         s.pc      = $urandom;
         s.dm      = $urandom;
         s.alu     = $urandom;
         s.sel     = 2'($urandom_range(0, 3));
         s.rd      = AW'($urandom_range(0, 3));
         s.we      = ($urandom_range(0, 3) != 0);
         s.flags   = NFLAG'($urandom);
         s.fwe     = NFLAG'($urandom);
         s.rfReady = ($urandom_range(0, 2) != 0);
         s.fwdAddr = AW'($urandom_range(0, 3));
         applyStimulus(s);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
      $finish;
   end
endmodule
